// File: rtl/nanosoc_ahb_meminit_mgr_if.sv
// AHB-Lite bus bundle between the memory-init manager and the bus matrix port.
// Master modport is the manager side; slave modport is the interconnect/memory side.
interface nanosoc_ahb_meminit_mgr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic              HWRITE;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    output HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/nanosoc_ahb_meminit_mgr.sv
// AHB-Lite manager that fills a word region with a pattern (FILL) or reads and compares it (CHECK).
// Define NANOSOC_MEMINIT_LFSR_EN for a Galois LFSR pattern instead of seed+i.
module nanosoc_ahb_meminit_mgr #(
  parameter int SYS_ADDR_W = 32,
  parameter int SYS_DATA_W = 32,
  parameter int CNT_W      = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [SYS_ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]      word_count_i,
  input  logic [31:0]           seed_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [SYS_ADDR_W-1:0] err_addr_o,
  nanosoc_ahb_meminit_mgr_if.master ahb
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DRAIN, S_DONE} state_e;

`ifdef NANOSOC_MEMINIT_LFSR_EN
  localparam logic [SYS_DATA_W-1:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [SYS_DATA_W-1:0] first_pat(input logic [SYS_DATA_W-1:0] s);
    return (s == '0) ? SYS_DATA_W'(1) : s;
  endfunction

  function automatic logic [SYS_DATA_W-1:0] next_pat(input logic [SYS_DATA_W-1:0] p);
    return (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
  endfunction
`else
  function automatic logic [SYS_DATA_W-1:0] first_pat(input logic [SYS_DATA_W-1:0] s);
    return s;
  endfunction

  function automatic logic [SYS_DATA_W-1:0] next_pat(input logic [SYS_DATA_W-1:0] p);
    return p + SYS_DATA_W'(1);
  endfunction
`endif

  state_e                state_q;
  logic                  mode_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      aidx_q;
  logic [SYS_DATA_W-1:0] apat_q;
  logic                  dval_q;
  logic [SYS_ADDR_W-1:0] dadr_q;
  logic [SYS_DATA_W-1:0] dpat_q;
  logic [SYS_ADDR_W-1:0] haddr_q;
  logic [1:0]            htrans_q;
  logic                  hwrite_q;
  logic [SYS_DATA_W-1:0] hwdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [SYS_ADDR_W-1:0] err_addr_q;

  // A pending data phase completes on HREADY; it fails on ERROR or a CHECK mismatch.
  logic dp_done;
  logic dp_fail;
  assign dp_done = dval_q & ahb.HREADY;
  assign dp_fail = dp_done & (ahb.HRESP | (mode_q & (ahb.HRDATA != dpat_q)));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      aidx_q     <= '0;
      apat_q     <= '0;
      dval_q     <= 1'b0;
      dadr_q     <= '0;
      dpat_q     <= '0;
      haddr_q    <= '0;
      htrans_q   <= HTRANS_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            mode_q     <= mode_i;
            cnt_q      <= word_count_i;
            aidx_q     <= '0;
            apat_q     <= first_pat(seed_i);
            dval_q     <= 1'b0;
            haddr_q    <= {base_addr_i[SYS_ADDR_W-1:2], 2'b00};
            err_q      <= 1'b0;
            err_addr_q <= '0;
            busy_q     <= 1'b1;
            if (word_count_i == '0) begin
              state_q <= S_DRAIN;
            end else begin
              state_q  <= S_ADDR;
              htrans_q <= HTRANS_NONSEQ;
              hwrite_q <= ~mode_i;
            end
          end
        end

        S_ADDR: begin
          if (dp_fail) begin
            htrans_q   <= HTRANS_IDLE;
            hwrite_q   <= 1'b0;
            dval_q     <= 1'b0;
            err_q      <= 1'b1;
            err_addr_q <= dadr_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else if (ahb.HREADY) begin
            // Address accepted: this beat moves into its data phase.
            dval_q <= 1'b1;
            dadr_q <= haddr_q;
            dpat_q <= apat_q;
            if (!mode_q) hwdata_q <= apat_q;
            if (aidx_q == cnt_q - CNT_W'(1)) begin
              htrans_q <= HTRANS_IDLE;
              hwrite_q <= 1'b0;
              state_q  <= S_DRAIN;
            end else begin
              aidx_q  <= aidx_q + CNT_W'(1);
              haddr_q <= haddr_q + SYS_ADDR_W'(4);
              apat_q  <= next_pat(apat_q);
            end
          end else if (dval_q && ahb.HRESP) begin
            // First ERROR cycle: withdraw the pipelined address, let DRAIN finish the response.
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            state_q  <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (!dval_q || dp_done) begin
            dval_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
            if (dp_fail) begin
              err_q      <= 1'b1;
              err_addr_q <= dadr_q;
            end
          end
        end

        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ahb.HADDR     = haddr_q;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HWDATA    = hwdata_q;
  assign ahb.HSIZE     = 3'b010;
  assign ahb.HBURST    = 3'b000;
  assign ahb.HPROT     = 4'b0011;
  assign ahb.HMASTLOCK = 1'b0;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_nanosoc_ahb_meminit_mgr.sv
// Directed bench for nanosoc_ahb_meminit_mgr with a small AHB memory slave model
// supporting wait states, a corrupted read word and a two-cycle ERROR response.
module tb_nanosoc_ahb_meminit_mgr;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  logic        start_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] base_addr_i = '0;
  logic [13:0] word_count_i = '0;
  logic [31:0] seed_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] err_addr_o;

  nanosoc_ahb_meminit_mgr_if #(.ADDR_W(32), .DATA_W(32)) ahb ();

  nanosoc_ahb_meminit_mgr #(.SYS_ADDR_W(32), .SYS_DATA_W(32), .CNT_W(14)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .base_addr_i  (base_addr_i),
    .word_count_i (word_count_i),
    .seed_i       (seed_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .err_addr_o   (err_addr_o),
    .ahb          (ahb)
  );

  // Slave model state
  logic [31:0] mem [0:15];
  logic        s_dval = 1'b0, s_dwrite = 1'b0, s_err = 1'b0, s_errph = 1'b0;
  logic [31:0] s_daddr = '0;
  int          s_wait = 0;
  int          ws_cfg = 0;
  logic [31:0] err_tgt = 32'hFFFF_FFFF;
  logic [31:0] bad_addr = 32'hFFFF_FFFF;

  // Monitor counters
  int          nonseq_cnt = 0, wr_cnt = 0, done_cnt = 0, post_err_nonseq = 0, stab_viol = 0;
  logic        stab_en = 1'b0;
  logic [1:0]  htrans_err2 = 2'b11;
  logic        prev_hready = 1'b1;
  logic [31:0] prev_haddr = '0, prev_hwdata = '0;
  logic [1:0]  prev_htrans = '0;

  assign ahb.HRESP  = s_dval & s_err;
  assign ahb.HREADY = !s_dval ? 1'b1 : (s_err ? s_errph : (s_wait == 0));
  assign ahb.HRDATA = (s_daddr == bad_addr) ? 32'hDEAD_BEEF : mem[s_daddr[5:2]];

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s_dval  <= 1'b0;
      s_err   <= 1'b0;
      s_errph <= 1'b0;
    end else begin
      if (s_dval) begin
        if (ahb.HREADY) begin
          s_dval <= 1'b0;
          if (s_dwrite && !s_err) begin
            mem[s_daddr[5:2]] <= ahb.HWDATA;
            wr_cnt <= wr_cnt + 1;
          end
          if (s_err) htrans_err2 <= ahb.HTRANS;
        end else if (s_err) begin
          s_errph <= 1'b1;
        end else begin
          s_wait <= s_wait - 1;
        end
      end
      if (ahb.HREADY && ahb.HTRANS == 2'b10) begin
        s_dval     <= 1'b1;
        s_daddr    <= ahb.HADDR;
        s_dwrite   <= ahb.HWRITE;
        s_wait     <= ws_cfg;
        s_err      <= (ahb.HADDR == err_tgt);
        s_errph    <= 1'b0;
        nonseq_cnt <= nonseq_cnt + 1;
      end
    end
  end

  always @(posedge HCLK) begin
    if (done_o) done_cnt <= done_cnt + 1;
    if (err_o && ahb.HTRANS == 2'b10) post_err_nonseq <= post_err_nonseq + 1;
    if (stab_en && !prev_hready &&
        (ahb.HADDR != prev_haddr || ahb.HWDATA != prev_hwdata || ahb.HTRANS != prev_htrans))
      stab_viol <= stab_viol + 1;
    prev_hready <= ahb.HREADY;
    prev_haddr  <= ahb.HADDR;
    prev_hwdata <= ahb.HWDATA;
    prev_htrans <= ahb.HTRANS;
  end

  int vec_cnt = 0;
  int mis_cnt = 0;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, act);
    end
  endtask

  // Issue one operation; lat = cycle (after the start-sampling edge) in which done is seen.
  task automatic run_op(input logic m, input logic [31:0] base, input logic [13:0] cnt,
                        input logic [31:0] seed, input bit poke,
                        output int lat, output logic busy1);
    @(negedge HCLK);
    start_i = 1'b1; mode_i = m; base_addr_i = base; word_count_i = cnt; seed_i = seed;
    @(negedge HCLK);
    start_i = 1'b0; mode_i = ~m; base_addr_i = 32'h1234_5678;
    word_count_i = 14'h3FFF; seed_i = 32'hCAFE_F00D;
    busy1 = busy_o;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      if (k > 1) @(negedge HCLK);
      start_i = (poke && k == 2);
      if (done_o) begin
        lat = k;
        break;
      end
    end
    start_i = 1'b0;
    if (lat < 0) chk_val("done_timeout", 32'd0, 32'd1);
  endtask

  int          lat;
  logic        b1;
  int          n0, w0, d0, e0, v0;

  initial begin
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    chk_val("rst_htrans",   32'(ahb.HTRANS), 32'd0);
    chk_val("rst_haddr",    ahb.HADDR, 32'd0);
    chk_val("rst_hwrite",   32'(ahb.HWRITE), 32'd0);
    chk_val("rst_hwdata",   ahb.HWDATA, 32'd0);
    chk_val("rst_busy",     32'(busy_o), 32'd0);
    chk_val("rst_done",     32'(done_o), 32'd0);
    chk_val("rst_err",      32'(err_o), 32'd0);
    chk_val("rst_err_addr", err_addr_o, 32'd0);
    chk_val("hsize",        32'(ahb.HSIZE), 32'd2);
    chk_val("hburst",       32'(ahb.HBURST), 32'd0);
    chk_val("hprot",        32'(ahb.HPROT), 32'd3);
    chk_val("hmastlock",    32'(ahb.HMASTLOCK), 32'd0);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);

    // FILL 4 words, with a start pulse and scrambled inputs while busy
    n0 = nonseq_cnt; w0 = wr_cnt; d0 = done_cnt;
    run_op(1'b0, 32'h4000_0000, 14'd4, 32'h1000_0000, 1'b1, lat, b1);
    repeat (2) @(negedge HCLK);
    chk_val("fill_lat",    32'(lat), 32'd6);
    chk_val("fill_busy1",  32'(b1), 32'd1);
    chk_val("fill_busy_after", 32'(busy_o), 32'd0);
    chk_val("fill_err",    32'(err_o), 32'd0);
    chk_val("fill_nonseq", 32'(nonseq_cnt - n0), 32'd4);
    chk_val("fill_writes", 32'(wr_cnt - w0), 32'd4);
    chk_val("fill_dones",  32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 4; i++)
      chk_val($sformatf("fill_mem%0d", i), mem[i], 32'h1000_0000 + 32'(i));

    // CHECK same region, clean
    n0 = nonseq_cnt;
    run_op(1'b1, 32'h4000_0000, 14'd4, 32'h1000_0000, 1'b0, lat, b1);
    repeat (2) @(negedge HCLK);
    chk_val("chk_lat",    32'(lat), 32'd6);
    chk_val("chk_err",    32'(err_o), 32'd0);
    chk_val("chk_nonseq", 32'(nonseq_cnt - n0), 32'd4);

    // CHECK with word 2 corrupted
    bad_addr = 32'h4000_0008;
    d0 = done_cnt; e0 = post_err_nonseq;
    run_op(1'b1, 32'h4000_0000, 14'd4, 32'h1000_0000, 1'b0, lat, b1);
    repeat (3) @(negedge HCLK);
    bad_addr = 32'hFFFF_FFFF;
    chk_val("mis_lat",      32'(lat), 32'd5);
    chk_val("mis_err",      32'(err_o), 32'd1);
    chk_val("mis_err_addr", err_addr_o, 32'h4000_0008);
    chk_val("mis_post_abort_nonseq", 32'(post_err_nonseq - e0), 32'd0);
    chk_val("mis_dones",    32'(done_cnt - d0), 32'd1);

    // FILL 3 words with 2 wait states per data phase
    ws_cfg = 2; stab_en = 1'b1;
    d0 = done_cnt; v0 = stab_viol;
    run_op(1'b0, 32'h4000_0010, 14'd3, 32'hA5A5_A5A0, 1'b0, lat, b1);
    repeat (2) @(negedge HCLK);
    ws_cfg = 0; stab_en = 1'b0;
    chk_val("ws_lat",    32'(lat), 32'd11);
    chk_val("ws_stable", 32'(stab_viol - v0), 32'd0);
    chk_val("ws_err",    32'(err_o), 32'd0);
    chk_val("ws_dones",  32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 3; i++)
      chk_val($sformatf("ws_mem%0d", i), mem[4+i], 32'hA5A5_A5A0 + 32'(i));

    // Slave ERROR on beat 1
    err_tgt = 32'h4000_0024;
    n0 = nonseq_cnt; w0 = wr_cnt; d0 = done_cnt;
    run_op(1'b0, 32'h4000_0020, 14'd4, 32'h0000_0001, 1'b0, lat, b1);
    repeat (2) @(negedge HCLK);
    err_tgt = 32'hFFFF_FFFF;
    chk_val("berr_lat",      32'(lat), 32'd5);
    chk_val("berr_err",      32'(err_o), 32'd1);
    chk_val("berr_err_addr", err_addr_o, 32'h4000_0024);
    chk_val("berr_htrans2",  32'(htrans_err2), 32'd0);
    chk_val("berr_nonseq",   32'(nonseq_cnt - n0), 32'd2);
    chk_val("berr_writes",   32'(wr_cnt - w0), 32'd1);
    chk_val("berr_dones",    32'(done_cnt - d0), 32'd1);
    chk_val("berr_mem0",     mem[8], 32'h0000_0001);

    // Zero-length request
    n0 = nonseq_cnt; d0 = done_cnt;
    run_op(1'b0, 32'h4000_0000, 14'd0, 32'h0, 1'b0, lat, b1);
    repeat (2) @(negedge HCLK);
    chk_val("zero_lat",    32'(lat), 32'd2);
    chk_val("zero_nonseq", 32'(nonseq_cnt - n0), 32'd0);
    chk_val("zero_err",    32'(err_o), 32'd0);
    chk_val("zero_dones",  32'(done_cnt - d0), 32'd1);

    // Reset in the middle of a FILL
    d0 = done_cnt;
    @(negedge HCLK);
    start_i = 1'b1; mode_i = 1'b0; base_addr_i = 32'h4000_0000;
    word_count_i = 14'd8; seed_i = 32'h55;
    @(negedge HCLK);
    start_i = 1'b0;
    repeat (2) @(negedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    chk_val("arst_htrans", 32'(ahb.HTRANS), 32'd0);
    chk_val("arst_busy",   32'(busy_o), 32'd0);
    chk_val("arst_haddr",  ahb.HADDR, 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);
    chk_val("arst_no_done", 32'(done_cnt - d0), 32'd0);
    run_op(1'b0, 32'h4000_0030, 14'd2, 32'h77, 1'b0, lat, b1);
    repeat (2) @(negedge HCLK);
    chk_val("post_rst_lat",  32'(lat), 32'd4);
    chk_val("post_rst_err",  32'(err_o), 32'd0);
    chk_val("post_rst_mem0", mem[12], 32'h77);
    chk_val("post_rst_mem1", mem[13], 32'h78);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vec_cnt);
    $fatal(1, "watchdog");
  end

endmodule
